// File: rtl/simon2share_ctrl.sv
// Sequencer for the 2-share Simon128/128 core: serialises plaintext/key shares, runs the core, returns ciphertext.
// Optional RUN-phase watchdog enabled by defining SIMON_CTRL_TIMEOUT_EN.
module simon2share_ctrl #(
  parameter int LOAD_BITS = 128,
  parameter int TIMEOUT   = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [LOAD_BITS-1:0] pt_a,
  input  logic [LOAD_BITS-1:0] pt_b,
  input  logic [LOAD_BITS-1:0] key_a,
  input  logic [LOAD_BITS-1:0] key_b,
  output logic                 data_ina,
  output logic                 data_inb,
  output logic [1:0]           data_rdy,
  input  logic                 core_done,
  input  logic [LOAD_BITS-1:0] core_cipher,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [LOAD_BITS-1:0] ct_data,
  output logic                 busy,
  output logic                 err
);

  // state    | meaning
  // IDLE     | waiting for a request, core held cleared
  // LOAD_PT  | shifting plaintext shares, data_rdy=1
  // LOAD_KEY | shifting key shares, data_rdy=2
  // RUN      | core running, waiting for core_done
  // OUT      | ciphertext held until consumer accepts
  typedef enum logic [2:0] {S_IDLE, S_LOAD_PT, S_LOAD_KEY, S_RUN, S_OUT} state_t;

  localparam int BW = $clog2(LOAD_BITS);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
`ifdef SIMON_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_t                 state, state_nxt;
  logic [BW-1:0]          bit_cnt;
  logic [7:0]             run_cnt;
  logic [2*LOAD_BITS-1:0] sh_a, sh_b;
  logic [1:0]             rdy_nxt;
  logic                   last_bit, timeout;

  assign start_ready = (state == S_IDLE);
  assign last_bit    = (bit_cnt == BW'(LOAD_BITS - 1));
  // run_cnt counts completed RUN cycles, so this fires at the end of RUN cycle TIMEOUT
  assign timeout     = TO_EN && (run_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    rdy_nxt   = 2'd0;
    case (state)
      S_IDLE:     if (start_valid) state_nxt = S_LOAD_PT;
      S_LOAD_PT:  if (last_bit) state_nxt = S_LOAD_KEY;
      S_LOAD_KEY: if (last_bit) state_nxt = S_RUN;
      S_RUN: begin
        if (core_done)    state_nxt = S_OUT;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_OUT:      if (ct_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_LOAD_PT:  rdy_nxt = 2'd1;
      S_LOAD_KEY: rdy_nxt = 2'd2;
      S_RUN:      rdy_nxt = 2'd3;
      default:    rdy_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      data_rdy <= 2'd0;
      data_ina <= 1'b0;
      data_inb <= 1'b0;
      ct_valid <= 1'b0;
      ct_data  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      run_cnt  <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
    end else begin
      state    <= state_nxt;
      data_rdy <= rdy_nxt;
      busy     <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            // bit 0 goes out immediately; the remaining 255 bits wait in the shifter, zero-padded
            data_ina <= pt_a[0];
            data_inb <= pt_b[0];
            sh_a     <= {1'b0, key_a, pt_a[LOAD_BITS-1:1]};
            sh_b     <= {1'b0, key_b, pt_b[LOAD_BITS-1:1]};
            bit_cnt  <= '0;
            err      <= 1'b0;
          end
        end
        S_LOAD_PT, S_LOAD_KEY: begin
          data_ina <= sh_a[0];
          data_inb <= sh_b[0];
          sh_a     <= sh_a >> 1;
          sh_b     <= sh_b >> 1;
          bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
          run_cnt  <= '0;
        end
        S_RUN: begin
          data_ina <= 1'b0;
          data_inb <= 1'b0;
          if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
          if (core_done) begin
            ct_data  <= core_cipher;
            ct_valid <= 1'b1;
          end else if (timeout) begin
            err <= 1'b1;
          end
        end
        S_OUT: begin
          if (ct_ready) ct_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
